// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// Optional stall watchdog is built when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_n_i,

    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,

    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,

    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic [NUM_MASTERS-1:0]   grant_reg, grant_next;
    logic [IW-1:0]            last_grant_reg, last_grant_next;

    logic [IW-1:0]            cand;
    logic [IW-1:0]            pick_idx;
    logic                     pick_found;
    logic                     wd_fire;

    logic [AW-1:0]            adr_masked [NUM_MASTERS];
    logic [DW-1:0]            dat_masked [NUM_MASTERS];
    logic [SW-1:0]            sel_masked [NUM_MASTERS];

    // Each master's bus fields are zeroed unless it owns the grant, so the
    // slave mux reduces to a plain OR over all masters.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
            assign adr_masked[gi] = grant_reg[gi] ? m_adr_i[gi*AW +: AW] : '0;
            assign dat_masked[gi] = grant_reg[gi] ? m_dat_i[gi*DW +: DW] : '0;
            assign sel_masked[gi] = grant_reg[gi] ? m_sel_i[gi*SW +: SW] : '0;
        end
    endgenerate

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_adr_o = s_adr_o | adr_masked[i];
            s_dat_o = s_dat_o | dat_masked[i];
            s_sel_o = s_sel_o | sel_masked[i];
        end
    end

    // grant_reg is zero in IDLE, so these collapse to 0 there; reset clears
    // grant_reg asynchronously and s_cyc_o follows without a clock edge.
    assign s_cyc_o = |(grant_reg & m_cyc_i);
    assign s_stb_o = |(grant_reg & m_stb_i);
    assign s_we_o  = |(grant_reg & m_we_i);

    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant_reg & {NUM_MASTERS{s_ack_i}};
    assign m_err_o = grant_reg & {NUM_MASTERS{s_err_i | wd_fire}};
    assign grant_o = grant_reg;

    // First requester at or after last_grant+1, wrapping around.
    always_comb begin
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = last_grant_reg;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand = IW'((int'(last_grant_reg) + off) % NUM_MASTERS);
            if (!pick_found && m_cyc_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        if (state_reg == IDLE) begin
            grant_next = '0;
            if (pick_found) begin
                grant_next      = ONE_HOT0 << pick_idx;
                last_grant_next = pick_idx;
                state_next      = GRANT;
            end
        end else begin
            if (!s_cyc_o || wd_fire) begin
                grant_next = '0;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IW'(NUM_MASTERS - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] wd_cnt_reg, wd_cnt_next;
    logic          timeout_reg, timeout_next;

    assign wd_fire = (state_reg == GRANT) && (wd_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    // Counts only cycles where a strobe is outstanding and the slave is silent.
    always_comb begin
        wd_cnt_next  = '0;
        timeout_next = timeout_reg | wd_fire;
        if ((state_reg == GRANT) && !wd_fire && s_stb_o && !s_ack_i && !s_err_i) begin
            wd_cnt_next = wd_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (4 masters, 32-bit bus) with a
// scoreboard of expected slave-side beats; watchdog case under WB_ARB_TIMEOUT_EN.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*DW/8-1:0] m_sel_i;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [DW/8-1:0]   s_sel_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i;
    logic [N-1:0]      grant_o;
    logic              timeout_o;

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb_q[$];

    wb_rr_arbiter #(
        .NUM_MASTERS   (N),
        .AW            (AW),
        .DW            (DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one acked beat from master m; the expected beat is queued first
    // and retired when the DUT routes the ack back.
    task automatic do_beat(input int m, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic [31:0] rdata);
        txn_t        t;
        txn_t        e;
        logic [3:0]  oh;
        oh = 4'b1 << m;
        t  = '{m, we, adr, dat, sel, rdata};
        sb_q.push_back(t);
        @(negedge clk);
        m_stb_i              = oh;
        m_we_i               = we ? oh : 4'b0;
        m_adr_i[m*AW +: AW]  = adr;
        m_dat_i[m*DW +: DW]  = dat;
        m_sel_i[m*4 +: 4]    = sel;
        s_ack_i              = 1'b1;
        s_dat_i              = rdata;
        #1;
        if (m_ack_o == 4'b0) begin
            check_val("ack_seen", {60'b0, m_ack_o}, {60'b0, oh});
        end else if (sb_q.size() == 0) begin
            check_val("sb_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("beat_grant", {60'b0, grant_o}, {60'b0, 4'b1 << e.m});
            check_val("beat_s_cyc", {63'b0, s_cyc_o}, 64'd1);
            check_val("beat_s_stb", {63'b0, s_stb_o}, 64'd1);
            check_val("beat_s_we",  {63'b0, s_we_o}, {63'b0, e.we});
            check_val("beat_s_adr", {32'b0, s_adr_o}, {32'b0, e.adr});
            check_val("beat_s_sel", {60'b0, s_sel_o}, {60'b0, e.sel});
            if (e.we) check_val("beat_s_dat", {32'b0, s_dat_o}, {32'b0, e.dat});
            check_val("beat_m_ack", {60'b0, m_ack_o}, {60'b0, 4'b1 << e.m});
            check_val("beat_m_dat", {32'b0, m_dat_o}, {32'b0, e.rdata});
        end
        $display("txn m%0d we=%0d adr=%h wdat=%h sel=%h rdat=%h grant=%b ack=%b",
                 m, we, s_adr_o, s_dat_o, s_sel_o, m_dat_o, grant_o, m_ack_o);
    endtask

    // Owner m drops cyc; expect one idle cycle (ignoring stray responses),
    // then the next grant once the request mask becomes cyc_next.
    task automatic release_owner(input int m, input logic [3:0] cyc_next, input logic [3:0] exp_grant);
        logic [3:0] oh;
        oh = 4'b1 << m;
        @(negedge clk);
        m_stb_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        m_cyc_i = m_cyc_i & ~oh;
        @(negedge clk);
        #1;
        check_val("idle_grant", {60'b0, grant_o}, 64'd0);
        check_val("idle_s_cyc", {63'b0, s_cyc_o}, 64'd0);
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        #1;
        check_val("idle_ack_drop", {60'b0, m_ack_o}, 64'd0);
        check_val("idle_err_drop", {60'b0, m_err_o}, 64'd0);
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        m_cyc_i = cyc_next;
        @(negedge clk);
        #1;
        check_val("next_grant", {60'b0, grant_o}, {60'b0, exp_grant});
        $display("txn release m%0d next_grant=%b", m, grant_o);
    endtask

    initial begin
        rst_n   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        #3;
        rst_n   = 1'b0;
        m_cyc_i = 4'b1111;

        // Reset holds everything off despite all requests.
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_grant",   {60'b0, grant_o}, 64'd0);
        check_val("rst_s_cyc",   {63'b0, s_cyc_o}, 64'd0);
        check_val("rst_timeout", {63'b0, timeout_o}, 64'd0);
        check_val("rst_m_ack",   {60'b0, m_ack_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_val("first_grant", {60'b0, grant_o}, 64'h1);
        check_val("first_s_cyc", {63'b0, s_cyc_o}, 64'd1);

        // Rotation with all four requesting.
        for (int i = 0; i < 4; i++) begin
            do_beat(i, 1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 32'h0);
            release_owner(i, 4'b1111, 4'b1 << ((i + 1) % 4));
        end

        // Routing: master 2 write then read.
        release_owner(0, 4'b0100, 4'b0100);
        do_beat(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
        do_beat(2, 1'b0, 32'h0000_0014, 32'h0, 4'hF, 32'h1234_5678);

        // Hold: master 1 bursts while master 3 waits.
        release_owner(2, 4'b0010, 4'b0010);
        m_cyc_i = m_cyc_i | 4'b1000;
        for (int b = 0; b < 4; b++) begin
            do_beat(1, 1'b0, 32'h200 + 32'(b * 4), 32'h0, 4'h3, 32'h5500_0000 + 32'(b));
        end
        release_owner(1, 4'b1000, 4'b1000);

        // Err pass-through on master 0.
        release_owner(3, 4'b0001, 4'b0001);
        @(negedge clk);
        m_stb_i = 4'b0001;
        s_err_i = 1'b1;
        #1;
        check_val("err_m_err", {60'b0, m_err_o}, 64'h1);
        check_val("err_m_ack", {60'b0, m_ack_o}, 64'd0);
        $display("txn err m0 m_err=%b m_ack=%b", m_err_o, m_ack_o);

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: master 3 strobes, slave never answers.
        release_owner(0, 4'b1000, 4'b1000);
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            if (j == 0) m_stb_i = 4'b1000;
            #1;
            if (j <= 16) check_val("wd_m_err", {60'b0, m_err_o}, (j == 15) ? 64'h8 : 64'h0);
            if (j == 16) check_val("wd_grant_idle", {60'b0, grant_o}, 64'd0);
            if (j >= 16) check_val("wd_timeout", {63'b0, timeout_o}, 64'd1);
        end
        $display("txn watchdog m3 timeout=%b", timeout_o);
        m_stb_i = '0;
        m_cyc_i = 4'b0001;
        repeat (2) @(negedge clk);
        #1;
        check_val("wd_regrant", {60'b0, grant_o}, 64'h1);
        check_val("wd_sticky", {63'b0, timeout_o}, 64'd1);
`endif

        // Reset mid-transfer drops s_cyc_o without a clock edge.
        @(negedge clk);
        s_err_i = 1'b0;
        m_stb_i = 4'b0001;
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async_s_cyc", {63'b0, s_cyc_o}, 64'd0);
        check_val("async_grant", {60'b0, grant_o}, 64'd0);
        check_val("async_timeout", {63'b0, timeout_o}, 64'd0);
        $display("txn async reset s_cyc=%b grant=%b", s_cyc_o, grant_o);

        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone slave bus among NUM_MASTERS Wishbone masters, e.g. multiple testbench stimulus masters or a CPU plus a DMA engine.
- Sits between the masters and the platform interconnect.
- Grants one master per bus cycle, holds the grant until that master drops cyc, and routes the slave's responses back to the granted master only.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (legal range 2..8).
- AW, 32, address width.
- DW, 32, data width. Select width is DW/8.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with WB_ARB_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  bus clock. All logic is on the rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- m_cyc_i  in  NUM_MASTERS  per-master cyc (bus request).
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*AW  flattened addresses. Master i occupies bits [i*AW +: AW].
- m_dat_i  in  NUM_MASTERS*DW  flattened write data.
- m_sel_i  in  NUM_MASTERS*DW/8  flattened byte selects.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  ack, routed to the granted master.
- m_err_o  out  NUM_MASTERS  err, routed to the granted master.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  muxed slave controls.
- s_adr_o  out  AW  muxed slave address.
- s_dat_o  out  DW  muxed slave write data.
- s_sel_o  out  DW/8  muxed slave byte selects.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- grant_o  out  NUM_MASTERS  one-hot registered grant.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:

Reset:
- wb_rst_n_i low forces state to IDLE, grant_o=0, all s_* outputs 0, m_ack_o=0, m_err_o=0, timeout_o=0 and watchdog counter=0.
- last_grant index resets to NUM_MASTERS-1, so master 0 has first priority.
- Reset asserted mid-cycle aborts the transfer immediately. The slave sees s_cyc_o fall asynchronously.

State IDLE:
- grant_o=0 and s_cyc_o=0.
- On a clock edge with any m_cyc_i high, select the first requester scanning from (last_grant+1) mod NUM_MASTERS upward, with wrap-around.
- Load grant_o with that one-hot value, update last_grant, and go to GRANT.
- Latency: cyc sampled at edge k gives grant_o and s_cyc_o high after edge k.

State GRANT:
- s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o are a combinational mux of the granted master's inputs, selected by grant_o.
- m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i for the granted master g. All other bits are 0.
- m_dat_o=s_dat_i unconditionally.
- The grant is held across any number of stb/ack beats while m_cyc_i[g] stays high. Requests from other masters are ignored.
- At an edge where m_cyc_i[g] is low, grant_o is cleared and the state returns to IDLE. There is always at least one idle cycle between owners.

Other rules:
- s_ack_i or s_err_i arriving while in IDLE is discarded.
- Simultaneous requests are resolved only by the round-robin pointer. No master waits more than NUM_MASTERS-1 grants.
- A single requester is re-granted every other cycle (IDLE, GRANT, IDLE, ...).

Optional Feature:
WB_ARB_TIMEOUT_EN

Defined:
- A counter of width $clog2(TIMEOUT_CYCLES)+1 increments on each GRANT cycle with s_stb_o=1 and s_ack_i=s_err_i=0. It clears on ack, on err, and in IDLE.
- When the counter reaches TIMEOUT_CYCLES-1:
  - m_err_o[g] pulses for exactly one cycle.
  - timeout_o sets and stays set until reset.
  - grant_o clears and the state forces to IDLE, even if m_cyc_i[g] is still high. The same master may be re-granted later through normal rotation.

Undefined:
- No counter logic is built.
- timeout_o is tied to 0.
- A stalled slave holds the grant indefinitely.

Test Plan:
1. Reset: hold wb_rst_n_i=0 with all m_cyc_i=4'b1111 -> grant_o=0, s_cyc_o=0, timeout_o=0. Release reset -> after the first edge grant_o=4'b0001.
2. Rotation: all four masters hold cyc; each drops cyc after one acked beat -> grant sequence is 0001, 0010, 0100, 1000, 0001, with one idle cycle between each pair of grants.
3. Routing:
   - Master 2 writes adr=32'h0000_0010, dat=32'hDEAD_BEEF, sel=4'hF -> s_adr_o/s_dat_o match those values and m_ack_o=4'b0100.
   - Master 2 then reads with s_dat_i=32'h1234_5678 -> m_dat_o=32'h1234_5678 and m_ack_o=4'b0100.
4. Hold: master 1 holds cyc over a 4-beat burst while master 3 requests -> grant_o stays 4'b0010 through all 4 acks. grant_o becomes 4'b1000 one idle cycle after master 1 drops cyc.
5. Err pass-through: slave asserts s_err_i while master 0 is granted -> m_err_o=4'b0001 and m_ack_o=0.
6. Watchdog (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never acks master 3 -> m_err_o=4'b1000 for exactly one cycle, 15 cycles after s_stb_o rose. timeout_o=1 and stays set. Grant returns to IDLE.
